spu_im_loader: RTL

//  Upstream boot stage for the spu: accepts a program as a valid/ready word stream, stores it
//  in an internal 256x16 instruction RAM, pulses spu start, serves the spu instruction-fetch

---
 rtl/spu_im_loader.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/spu_im_loader.sv
// -----------------------------------------------------------------------------
// spu_im_loader
//   Boot stage in front of the spu. A program arrives as a valid/ready word
//   stream and is written into an internal 2**AW x DW instruction RAM. Once the
//   last word is stored the loader pulses start for START_LEN cycles, then
//   serves the spu instruction-fetch port while the spu runs. The run ends when
//   the spu raises stop, or when the optional RUN_TIMEOUT expires.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   ld_valid   load beat valid
//   ld_ready   loader can accept a beat (IDLE/LOAD/DONE, never during rst)
//   ld_data    instruction word of the current beat
//   ld_last    current beat carries the final program word
//   start      start pulse to the spu (START_LEN cycles)
//   stop       spu finished (only looked at in RUN)
//   im_rd      spu instruction read enable
//   im_addr    spu instruction address
//   im_r_data  instruction read data, one cycle after im_rd
//   busy       high in START or RUN
//   done       high in DONE
//   word_cnt   number of words in the current program (1..2**AW)
//   ovf_err    sticky: program longer than the RAM, truncated
//   tmo_err    sticky: run aborted by RUN_TIMEOUT
// -----------------------------------------------------------------------------
module spu_im_loader #(
  parameter int AW          = 8,
  parameter int DW          = 16,
  parameter int START_LEN   = 1,
  parameter int RUN_TIMEOUT = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  output logic          start,
  input  logic          stop,
  input  logic          im_rd,
  input  logic [AW-1:0] im_addr,
  output logic [DW-1:0] im_r_data,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   word_cnt,
  output logic          ovf_err,
  output logic          tmo_err
);

  localparam int DEPTH = 2 ** AW;

  localparam logic [AW-1:0] PTR_ONE    = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_MAX    = {AW{1'b1}};
  localparam logic [AW:0]   CNT_ONE    = {{AW{1'b0}}, 1'b1};
  localparam logic [3:0]    START_LAST = 4'(START_LEN - 1);
  localparam logic [23:0]   TMO_LAST   = 24'(RUN_TIMEOUT - 1);
  localparam logic          TMO_EN     = (RUN_TIMEOUT != 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [AW-1:0] wr_ptr, wr_ptr_nxt;
  logic [AW:0]   word_cnt_nxt;
  logic [3:0]    start_cnt, start_cnt_nxt;
  logic [23:0]   run_cnt, run_cnt_nxt;
  logic          ovf_nxt;
  logic          tmo_nxt;
  logic          start_nxt;
  logic          busy_nxt;
  logic          done_nxt;

  logic          ready_state;
  logic          beat;
  logic [AW-1:0] wr_addr;

  logic [DW-1:0] mem [DEPTH];

  // ld_ready comes from the state register; rst gates it so no beat can be
  // accepted while reset is asserted.
  assign ready_state = (state == S_IDLE) || (state == S_LOAD) || (state == S_DONE);
  assign ld_ready    = ready_state & ~rst;
  assign beat        = ld_valid & ld_ready;

  // A beat taken in IDLE or DONE starts a fresh program at address 0.
  assign wr_addr     = (state == S_LOAD) ? wr_ptr : {AW{1'b0}};

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state;
    wr_ptr_nxt    = wr_ptr;
    word_cnt_nxt  = word_cnt;
    start_cnt_nxt = 4'd0;
    run_cnt_nxt   = 24'd0;
    ovf_nxt       = ovf_err;
    tmo_nxt       = tmo_err;

    case (state)
      S_IDLE, S_DONE: begin
        if (beat) begin
          wr_ptr_nxt   = PTR_ONE;
          word_cnt_nxt = CNT_ONE;
          ovf_nxt      = 1'b0;
          tmo_nxt      = 1'b0;
          if (ld_last) begin
            state_nxt = S_START;
          end else begin
            state_nxt = S_LOAD;
          end
        end else begin
          state_nxt = state;
        end
      end

      S_LOAD: begin
        if (beat) begin
          wr_ptr_nxt   = wr_ptr + PTR_ONE;
          word_cnt_nxt = word_cnt + CNT_ONE;
          if (ld_last) begin
            state_nxt = S_START;
          end else if (wr_ptr == PTR_MAX) begin
            // RAM full: keep what fits and launch anyway, no wrap-around.
            ovf_nxt   = 1'b1;
            state_nxt = S_START;
          end else begin
            state_nxt = S_LOAD;
          end
        end else begin
          state_nxt = S_LOAD;
        end
      end

      S_START: begin
        if (start_cnt == START_LAST) begin
          state_nxt = S_RUN;
        end else begin
          start_cnt_nxt = start_cnt + 4'd1;
        end
      end

      S_RUN: begin
        // stop is checked first so that a stop arriving on the timeout edge
        // ends the run cleanly without flagging tmo_err.
        if (stop) begin
          state_nxt = S_DONE;
        end else if (TMO_EN && (run_cnt == TMO_LAST)) begin
          state_nxt = S_DONE;
          tmo_nxt   = 1'b1;
        end else begin
          run_cnt_nxt = run_cnt + 24'd1;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    start_nxt = (state_nxt == S_START);
    busy_nxt  = (state_nxt == S_START) || (state_nxt == S_RUN);
    done_nxt  = (state_nxt == S_DONE);
  end

  // Control state, counters, flags and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      wr_ptr    <= {AW{1'b0}};
      word_cnt  <= {(AW+1){1'b0}};
      start_cnt <= 4'd0;
      run_cnt   <= 24'd0;
      ovf_err   <= 1'b0;
      tmo_err   <= 1'b0;
      start     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      wr_ptr    <= wr_ptr_nxt;
      word_cnt  <= word_cnt_nxt;
      start_cnt <= start_cnt_nxt;
      run_cnt   <= run_cnt_nxt;
      ovf_err   <= ovf_nxt;
      tmo_err   <= tmo_nxt;
      start     <= start_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

  // Instruction RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (beat) begin
      mem[wr_addr] <= ld_data;
    end
  end

  // Fetch port: one-cycle read latency, holds when im_rd is low. A read and
  // write to the same address on one edge returns the previous contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      im_r_data <= {DW{1'b0}};
    end else if (im_rd) begin
      im_r_data <= mem[im_addr];
    end
  end

endmodule
